// File: rtl/simon_ks_ctrl_pkg.sv
// rtl/simon_ks_ctrl_pkg.sv - shared FSM type, key-schedule mode codes and default sizes
package simon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ks_state_t;

  // data_rdy codes understood by the key schedule; code 1 is never driven
  localparam logic [1:0] DR_HOLD   = 2'd0;
  localparam logic [1:0] DR_LOAD   = 2'd2;
  localparam logic [1:0] DR_EXPAND = 2'd3;

  // SIMON-128/128
  localparam int DEF_ROUNDS   = 68;
  localparam int DEF_KEY_BITS = 128;

endpackage

// File: rtl/simon_ks_ctrl_if.sv
// rtl/simon_ks_ctrl_if.sv - host and key-schedule signals of the key-schedule controller
interface simon_ks_ctrl_if;

  logic       start;
  logic       abort;
  logic       key_bit;
  logic       key_valid;
  logic       key_ready;
  logic [1:0] data_rdy;
  logic [7:0] counter;
  logic       data_in;
  logic       busy;
  logic       rk_valid;
  logic [6:0] round_idx;
  logic       done;

  // host side drives requests and the serial key
  modport master (
    output start, abort, key_bit, key_valid,
    input  key_ready, data_rdy, counter, data_in, busy, rk_valid, round_idx, done
  );

  // controller side
  modport slave (
    input  start, abort, key_bit, key_valid,
    output key_ready, data_rdy, counter, data_in, busy, rk_valid, round_idx, done
  );

endinterface

// File: rtl/simon_ks_ctrl.sv
// rtl/simon_ks_ctrl.sv - sequences serial key load and fixed-length expansion of a SIMON key schedule
module simon_ks_ctrl
  import simon_pkg::*;
#(
  parameter int ROUNDS   = DEF_ROUNDS,
  parameter int KEY_BITS = DEF_KEY_BITS
) (
  input  logic           clk,
  input  logic           rst,
  simon_ks_ctrl_if.slave ks
);

  // 2*ROUNDS must fit the 8-bit counter and the key length the 8-bit load count
  generate
    if (ROUNDS < 1 || ROUNDS > 127) begin : g_bad_rounds
      $error("simon_ks_ctrl: ROUNDS must be in 1..127");
    end
    if (KEY_BITS < 1 || KEY_BITS > 256) begin : g_bad_key_bits
      $error("simon_ks_ctrl: KEY_BITS must be in 1..256");
    end
  endgenerate

  localparam logic [7:0] LAST_CNT = 8'(2 * ROUNDS - 1);
  localparam logic [7:0] LAST_BIT = 8'(KEY_BITS - 1);

  ks_state_t  state;
  logic [7:0] counter_q;
  logic [7:0] load_cnt;
  logic       busy_q;
  logic       key_ready_q;
  logic       done_q;

  // Controller FSM: abort wins over every other request, counter only moves in RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      counter_q   <= 8'd0;
      load_cnt    <= 8'd0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (ks.abort) begin
      state       <= ST_IDLE;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (ks.start) begin
            state       <= ST_LOAD;
            load_cnt    <= 8'd0;
            busy_q      <= 1'b1;
            key_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          // a bit is consumed only on key_valid; gaps leave the count untouched
          if (ks.key_valid) begin
            if (load_cnt == LAST_BIT) begin
              state       <= ST_RUN;
              counter_q   <= 8'd0;
              key_ready_q <= 1'b0;
            end else begin
              load_cnt <= load_cnt + 8'd1;
            end
          end
        end
        ST_RUN: begin
          // never stalls: exactly 2*ROUNDS cycles, counter left at its last value
          if (counter_q == LAST_CNT) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            counter_q <= counter_q + 8'd1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Schedule mode: follows key_valid in LOAD so gap cycles hold the schedule
  always_comb begin
    ks.data_rdy = DR_HOLD;
    if (!ks.abort) begin
      case (state)
        ST_LOAD: ks.data_rdy = ks.key_valid ? DR_LOAD : DR_HOLD;
        ST_RUN:  ks.data_rdy = DR_EXPAND;
        default: ks.data_rdy = DR_HOLD;
      endcase
    end
  end

  // Round keys appear on even counter values; odd cycles are the schedule's update cycles
  always_comb begin
    ks.rk_valid  = 1'b0;
    ks.round_idx = 7'd0;
    if (state == ST_RUN) begin
      ks.rk_valid  = ~counter_q[0];
      ks.round_idx = counter_q[7:1];
    end
  end

  assign ks.data_in   = (state == ST_LOAD) ? ks.key_bit : 1'b0;
  assign ks.counter   = counter_q;
  assign ks.key_ready = key_ready_q;
  assign ks.busy      = busy_q;
  assign ks.done      = done_q;

endmodule

// File: tb/tb_simon_ks_ctrl.sv
// tb/tb_simon_ks_ctrl.sv - randomized self-checking bench for simon_ks_ctrl with a paired key schedule
module tb_simon_ks_ctrl;
  import simon_pkg::*;

  localparam int ROUNDS   = 68;
  localparam int KEY_BITS = 128;
  localparam int RUN_CYC  = 2 * ROUNDS;

  logic clk = 1'b0;
  logic rst;

  simon_ks_ctrl_if ks_if ();

  simon_ks_ctrl #(.ROUNDS(ROUNDS), .KEY_BITS(KEY_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [127:0] sched;                  // paired key schedule, {KX, KY} once loaded
  logic [63:0]  ref_rk [0:ROUNDS-1];    // expected round keys computed straight from the key
  logic [63:0]  zbits = 64'h3DC94C3A046D678B;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // two-word SIMON-style key update used by both the schedule and the reference
  function automatic logic [63:0] ks_f(input logic [63:0] k0, input logic [63:0] k1, input int i);
    logic [63:0] t;
    t = ror64(k1, 3);
    t = t ^ ror64(t, 1);
    return 64'hFFFF_FFFF_FFFF_FFFC ^ {63'd0, zbits[i % 62]} ^ k0 ^ t;
  endfunction

  task automatic build_ref(input logic [127:0] key);
    ref_rk[0] = key[63:0];
    ref_rk[1] = key[127:64];
    for (int i = 2; i < ROUNDS; i++) ref_rk[i] = ks_f(ref_rk[i-2], ref_rk[i-1], i - 2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start(output int t0);
    ks_if.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    chk("idle_busy", 128'(ks_if.busy), 128'(0));
    chk("idle_data_rdy", 128'(ks_if.data_rdy), 128'(DR_HOLD));
    tick();
    ks_if.start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid pattern 1,0,0, 2: random gaps
  task automatic load_key(input logic [127:0] key, input int mode, input int abort_at);
    int i = 0;
    int ph = 0;
    int n_load = 0;
    int budget = 0;
    logic v;
    logic ab;
    sched = '0;
    while (i < KEY_BITS) begin
      if (budget > 4000) begin
        chk("load_timeout", 128'(i), 128'(KEY_BITS));
        return;
      end
      budget++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (ph % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      ab = (i == abort_at);
      if (ab) v = 1'b1;
      ks_if.abort     = ab;
      ks_if.key_valid = v;
      ks_if.key_bit   = v ? key[i] : 1'($urandom);
      @(negedge clk);
      chk("load_key_ready", 128'(ks_if.key_ready), 128'(1));
      chk("load_data_rdy", 128'(ks_if.data_rdy), 128'((v && !ab) ? DR_LOAD : DR_HOLD));
      if (v && !ab) chk("load_data_in", 128'(ks_if.data_in), 128'(key[i]));
      if (ks_if.data_rdy == DR_LOAD) begin
        sched = {ks_if.data_in, sched[127:1]};
        n_load++;
      end
      if (ab) begin
        tick();
        ks_if.abort     = 1'b0;
        ks_if.key_valid = 1'b0;
        return;
      end
      if (v) begin
        i++;
        if (i == 64) chk("ky_after_bit63", 128'(sched[127:64]), 128'(key[63:0]));
      end
      ph++;
      tick();
    end
    ks_if.key_valid = 1'b0;
    chk("load_cycle_count", 128'(n_load), 128'(KEY_BITS));
    chk("loaded_key", sched, key);
  endtask

  task automatic run_expand(input bit start_in_run, input bit start_in_done, input int rst_at,
                            input int t0, input int exp_latency);
    for (int c = 0; c < RUN_CYC; c++) begin
      ks_if.start = (start_in_run && c == 5);
      if (c == rst_at) rst = 1'b1;
      @(negedge clk);
      chk("run_data_rdy", 128'(ks_if.data_rdy), 128'(DR_EXPAND));
      chk("run_counter", 128'(ks_if.counter), 128'(c));
      chk("run_rk_valid", 128'(ks_if.rk_valid), 128'(c % 2 == 0));
      chk("run_busy", 128'(ks_if.busy), 128'(1));
      chk("run_done", 128'(ks_if.done), 128'(0));
      chk("run_key_ready", 128'(ks_if.key_ready), 128'(0));
      if (c % 2 == 0) begin
        chk("run_round_idx", 128'(ks_if.round_idx), 128'(c / 2));
        chk("round_key", 128'(sched[63:0]), 128'(ref_rk[c/2]));
      end else begin
        sched = {ks_f(sched[63:0], sched[127:64], int'(ks_if.counter[7:1])), sched[127:64]};
      end
      if (c == rst_at) begin
        tick();
        rst = 1'b0;
        ks_if.start = 1'b0;
        @(negedge clk);
        chk("rst_counter", 128'(ks_if.counter), 128'(0));
        chk("rst_data_rdy", 128'(ks_if.data_rdy), 128'(DR_HOLD));
        chk("rst_busy", 128'(ks_if.busy), 128'(0));
        chk("rst_rk_valid", 128'(ks_if.rk_valid), 128'(0));
        chk("rst_round_idx", 128'(ks_if.round_idx), 128'(0));
        chk("rst_done", 128'(ks_if.done), 128'(0));
        tick();
        return;
      end
      tick();
    end
    ks_if.start = start_in_done;
    @(negedge clk);
    chk("done_pulse", 128'(ks_if.done), 128'(1));
    chk("done_data_rdy", 128'(ks_if.data_rdy), 128'(DR_HOLD));
    chk("done_busy", 128'(ks_if.busy), 128'(1));
    chk("done_counter_hold", 128'(ks_if.counter), 128'(RUN_CYC - 1));
    if (exp_latency > 0) chk("latency", 128'(cyc - t0 + 1), 128'(exp_latency));
    tick();
    ks_if.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("post_done", 128'(ks_if.done), 128'(0));
      chk("post_busy", 128'(ks_if.busy), 128'(0));
      chk("post_key_ready", 128'(ks_if.key_ready), 128'(0));
      chk("post_counter_hold", 128'(ks_if.counter), 128'(RUN_CYC - 1));
      tick();
    end
  endtask

  task automatic full_run(input logic [127:0] key, input int mode, input bit s_run, input bit s_done);
    int t0;
    build_ref(key);
    do_start(t0);
    load_key(key, mode, -1);
    run_expand(s_run, s_done, -1, t0, (mode == 0) ? (1 + KEY_BITS + RUN_CYC + 1) : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key;
    int t0;
    rst             = 1'b1;
    ks_if.start     = 1'b0;
    ks_if.abort     = 1'b0;
    ks_if.key_bit   = 1'b0;
    ks_if.key_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("reset_busy", 128'(ks_if.busy), 128'(0));
    chk("reset_data_rdy", 128'(ks_if.data_rdy), 128'(0));
    chk("reset_counter", 128'(ks_if.counter), 128'(0));
    chk("reset_outputs", 128'({ks_if.key_ready, ks_if.rk_valid, ks_if.done, ks_if.data_in}), 128'(0));
    chk("reset_round_idx", 128'(ks_if.round_idx), 128'(0));
    rst = 1'b0;
    tick();

    // key_valid in IDLE ignored; start together with abort stays IDLE
    ks_if.key_valid = 1'b1;
    ks_if.key_bit   = 1'b1;
    @(negedge clk);
    chk("idle_kv_key_ready", 128'(ks_if.key_ready), 128'(0));
    chk("idle_kv_data_rdy", 128'(ks_if.data_rdy), 128'(0));
    tick();
    ks_if.key_valid = 1'b0;
    ks_if.start = 1'b1;
    ks_if.abort = 1'b1;
    @(negedge clk);
    chk("start_abort_data_rdy", 128'(ks_if.data_rdy), 128'(0));
    tick();
    ks_if.start = 1'b0;
    ks_if.abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", 128'(ks_if.busy), 128'(0));
    chk("start_abort_key_ready", 128'(ks_if.key_ready), 128'(0));
    tick();

    // back-to-back load with start pokes in RUN and DONE, then gapped loads
    key = {$urandom, $urandom, $urandom, $urandom};
    full_run(key, 0, 1'b1, 1'b1);
    full_run(key, 1, 1'b0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      full_run(key, 2, 1'b0, 1'b0);
    end

    // abort at load bit 50, then a clean reload of the same key
    key = {$urandom, $urandom, $urandom, $urandom};
    build_ref(key);
    do_start(t0);
    load_key(key, 0, 50);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_busy", 128'(ks_if.busy), 128'(0));
      chk("abort_key_ready", 128'(ks_if.key_ready), 128'(0));
      chk("abort_data_rdy", 128'(ks_if.data_rdy), 128'(0));
      chk("abort_no_done", 128'(ks_if.done), 128'(0));
      tick();
    end
    full_run(key, 0, 1'b0, 1'b0);

    // synchronous reset in the middle of expansion
    key = {$urandom, $urandom, $urandom, $urandom};
    build_ref(key);
    do_start(t0);
    load_key(key, 0, -1);
    run_expand(1'b0, 1'b0, 37, t0, 0);

    key = {$urandom, $urandom, $urandom, $urandom};
    full_run(key, 2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
